serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 86 ++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, through a registered carry.
// Reports sum, carry-out and signed overflow with a one-cycle done strobe.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nxt, last, accept;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    s_bit     = a_sr[0] ^ b_sr[0] ^ carry;
    c_nxt     = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    last      = (cnt == CW'(WIDTH - 1));
    accept    = start && (state != RUN);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and beats start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {s_bit, res_sr[WIDTH-1:1]};
      carry  <= c_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        // On the MSB step the registered carry is the carry into the MSB.
        sum  <= {s_bit, res_sr[WIDTH-1:1]};
        cout <= c_nxt;
        ovf  <= carry ^ c_nxt;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=4 and a WIDTH=8 instance share clock and reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  int checks = 0;
  int errors = 0;
  int ndone4 = 0;
  int ndone8 = 0;

  // Expected result packed as {ovf, cout, sum[7:0]}.
  logic [9:0] q4[$];
  logic [9:0] q8[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] model(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv);
    logic [8:0] full;
    logic [7:0] s;
    logic       co, ov;
    if (w8) begin
      full = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
      s    = full[7:0];
      co   = full[8];
      ov   = (av[7] == bv[7]) && (s[7] != av[7]);
    end else begin
      full = {5'd0, av[3:0]} + {5'd0, bv[3:0]} + {8'd0, cv};
      s    = {4'h0, full[3:0]};
      co   = full[4];
      ov   = (av[3] == bv[3]) && (s[3] != av[3]);
    end
    return {ov, co, s};
  endfunction

  always @(negedge clk) begin
    if (done4) begin
      ndone4++;
      if (q4.size() == 0) check("sb4_unexpected_done", 1, 0);
      else check("res4", {22'd0, ovf4, cout4, 4'h0, sum4}, {22'd0, q4.pop_front()});
    end
    if (done8) begin
      ndone8++;
      if (q8.size() == 0) check("sb8_unexpected_done", 1, 0);
      else check("res8", {22'd0, ovf8, cout8, sum8}, {22'd0, q8.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv);
    if (w8) begin
      start8 = s; a8 = av; b8 = bv; cin8 = cv;
    end else begin
      start4 = s; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv;
    end
  endtask

  // One start pulse from IDLE; checks busy/done cycle by cycle and the single-cycle strobe.
  task automatic run_op(input bit w8, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int lat;
    lat = w8 ? 8 : 4;
    drive(w8, 1'b1, av, bv, cv);
    if (w8) q8.push_back(model(1'b1, av, bv, cv));
    else    q4.push_back(model(1'b0, av, bv, cv));
    tick();
    drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    check("busy_after_start", w8 ? busy8 : busy4, 1);
    for (int i = 1; i <= lat; i++) begin
      tick();
      check(i < lat ? "busy_run" : "busy_end", w8 ? busy8 : busy4, (i < lat) ? 1 : 0);
      check(i < lat ? "done_early" : "done_at_latency", w8 ? done8 : done4, (i < lat) ? 0 : 1);
    end
    tick();
    check("done_one_cycle", w8 ? done8 : done4, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 8'h0F, 8'h0F, 1'b1);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    repeat (2) tick();
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_out4", {ovf4, cout4, sum4}, 0);
    check("rst_busy8", busy8, 0);
    check("rst_out8", {done8, ovf8, cout8, sum8}, 0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    check("no_op_after_rst", busy4 | busy8, 0);

    // Directed WIDTH=4 cases, then hold of the last result.
    run_op(1'b0, 8'h03, 8'h05, 1'b0);
    run_op(1'b0, 8'h0F, 8'h01, 1'b0);
    run_op(1'b0, 8'h07, 8'h00, 1'b1);
    repeat (3) tick();
    check("hold_sum", {ovf4, cout4, sum4}, 6'b10_1000);

    // Start pulsed mid-run must be ignored.
    drive(1'b0, 1'b1, 8'h02, 8'h03, 1'b0);
    q4.push_back(model(1'b0, 8'h02, 8'h03, 1'b0));
    tick();
    drive(1'b0, 1'b0, 8'h02, 8'h03, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) tick();
    check("ign_done_k4", done4, 1);
    tick();
    n = ndone4;
    repeat (8) tick();
    check("ign_no_second", ndone4, n);
    check("ign_sum", sum4, 4'h5);

    // Start held high: acceptance every 5th edge, accepted again from DONE.
    for (int op = 0; op < 4; op++) begin
      logic [7:0] av, bv;
      logic       cv;
      av = 8'($urandom_range(0, 15));
      bv = 8'($urandom_range(0, 15));
      cv = 1'($urandom);
      drive(1'b0, 1'b1, av, bv, cv);
      q4.push_back(model(1'b0, av, bv, cv));
      tick();
      check("b2b_busy", busy4, 1);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      repeat (4) tick();
      check("b2b_done", done4, 1);
      if (op == 3) start4 = 1'b0;
    end
    tick();
    check("b2b_idle", busy4 | done4, 0);

    // Reset mid-run aborts with no done.
    drive(1'b0, 1'b1, 8'h09, 8'h06, 1'b0);
    q4.push_back(model(1'b0, 8'h09, 8'h06, 1'b0));
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(q4.pop_back());
    check("abort_out", {busy4, done4, ovf4, cout4, sum4}, 0);
    n = ndone4;
    repeat (6) tick();
    check("abort_no_done", ndone4, n);
    run_op(1'b0, 8'h04, 8'h04, 1'b1);

    // WIDTH=8 corner and randoms.
    run_op(1'b1, 8'hFF, 8'hFF, 1'b1);
    run_op(1'b1, 8'h7F, 8'h01, 1'b0);
    for (int i = 0; i < 200; i++)
      run_op(1'b0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom));
    for (int i = 0; i < 30; i++)
      run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));

    repeat (2) tick();
    check("sb4_drained", q4.size(), 0);
    check("sb8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
